debounce_bank: RTL and testbench

Parametrised multi-channel successor to the single-button debouncer. It sits between raw button or switch pins and user logic, on the panel clock domain. Each channel provides:
- input synchronisation;
- polarity normalisation;
- restart-on-bounce debouncing;
- single-cycle press and release pulses with the correct edge sense;
- long-press detection, plus an optional auto-repeat pulse train.

---
 rtl/debounce_bank.sv | 183 ++++++++++++++++++
 tb/tb_debounce_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, restart-on-bounce debouncer and
// hold / auto-repeat detector, all channels sharing one hold-tick prescaler.
module debounce_bank #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int PRESCALE        = 30000,
   parameter int HOLD_TICKS      = 500,
   parameter int REPEAT_TICKS    = 100
) (
   input  logic                i_clk,
   input  logic                i_resetn,
   input  logic [CHANNELS-1:0] i_pins,
   output logic [CHANNELS-1:0] o_pressed,
   output logic [CHANNELS-1:0] o_press,
   output logic [CHANNELS-1:0] o_release,
   output logic [CHANNELS-1:0] o_long_press,
   output logic [CHANNELS-1:0] o_repeat
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
   localparam logic          REL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
   localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS);
   localparam logic [RW-1:0] REP_END  = RW'(REPEAT_TICKS);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HOLDING   = 2'd1,
      ST_REPEATING = 2'd2
   } hold_state_t;

   logic [SYNC_STAGES-1:0] r_sync     [CHANNELS];
   logic [DW-1:0]          r_db_cnt   [CHANNELS];
   logic [DW-1:0]          w_db_nxt   [CHANNELS];
   hold_state_t            r_state    [CHANNELS];
   hold_state_t            w_state_nxt[CHANNELS];
   logic [HW-1:0]          r_hold_cnt [CHANNELS];
   logic [HW-1:0]          w_hold_nxt [CHANNELS];
   logic [RW-1:0]          r_rep_cnt  [CHANNELS];
   logic [RW-1:0]          w_rep_nxt  [CHANNELS];
   logic [CHANNELS-1:0]    r_pressed, r_press, r_release, r_long, r_repeat;
   logic [CHANNELS-1:0]    w_norm, w_rise, w_fall, w_long_nxt, w_rpt_nxt;
   logic [PW-1:0]          r_presc;
   logic                   w_tick;

   assign w_tick = (r_presc == PS_LAST);

   // Debounce decision: any sample equal to the current level restarts the count.
   always_comb begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
         w_norm[ch]   = r_sync[ch][SYNC_STAGES-1] ^ REL;
         w_rise[ch]   = 1'b0;
         w_fall[ch]   = 1'b0;
         w_db_nxt[ch] = r_db_cnt[ch];
         if (w_norm[ch] == r_pressed[ch]) begin
            w_db_nxt[ch] = '0;
         end else if (r_db_cnt[ch] == DB_LAST) begin
            w_db_nxt[ch] = '0;
            w_rise[ch]   = w_norm[ch];
            w_fall[ch]   = ~w_norm[ch];
         end else begin
            w_db_nxt[ch] = r_db_cnt[ch] + DW'(1);
         end
      end
   end

   // Synchronisers, debounce counters and level/edge outputs.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_sync[ch]   <= {SYNC_STAGES{REL}};
            r_db_cnt[ch] <= '0;
         end
         r_pressed <= '0;
         r_press   <= '0;
         r_release <= '0;
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_sync[ch]   <= {r_sync[ch][SYNC_STAGES-2:0], i_pins[ch]};
            r_db_cnt[ch] <= w_db_nxt[ch];
         end
         r_pressed <= r_pressed ^ (w_rise | w_fall);
         r_press   <= w_rise;
         r_release <= w_fall;
      end
   end

   // Shared free-running hold-tick prescaler.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_presc <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
   end

   // Hold FSM: a release decided this cycle pre-empts any tick, and the tick
   // coinciding with the press decision is deliberately not counted.
   always_comb begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
         w_state_nxt[ch] = r_state[ch];
         w_hold_nxt[ch]  = r_hold_cnt[ch];
         w_rep_nxt[ch]   = r_rep_cnt[ch];
         w_long_nxt[ch]  = 1'b0;
         w_rpt_nxt[ch]   = 1'b0;
         if (w_rise[ch]) begin
            w_state_nxt[ch] = ST_HOLDING;
            w_hold_nxt[ch]  = '0;
            w_rep_nxt[ch]   = '0;
         end else if (!r_pressed[ch] || w_fall[ch]) begin
            w_state_nxt[ch] = ST_IDLE;
            w_hold_nxt[ch]  = '0;
            w_rep_nxt[ch]   = '0;
         end else begin
            case (r_state[ch])
               ST_IDLE: begin
                  w_state_nxt[ch] = ST_HOLDING;
               end
               ST_HOLDING: begin
                  if (w_tick && (r_hold_cnt[ch] + HW'(1) == HOLD_END)) begin
                     w_long_nxt[ch]  = 1'b1;
                     w_state_nxt[ch] = ST_REPEATING;
                     w_rep_nxt[ch]   = '0;
                  end else if (w_tick) begin
                     w_hold_nxt[ch] = r_hold_cnt[ch] + HW'(1);
                  end else begin
                     w_hold_nxt[ch] = r_hold_cnt[ch];
                  end
               end
               ST_REPEATING: begin
                  if (w_tick && (REPEAT_TICKS != 0) && (r_rep_cnt[ch] + RW'(1) == REP_END)) begin
                     w_rpt_nxt[ch] = 1'b1;
                     w_rep_nxt[ch] = '0;
                  end else if (w_tick && (REPEAT_TICKS != 0)) begin
                     w_rep_nxt[ch] = r_rep_cnt[ch] + RW'(1);
                  end else begin
                     w_rep_nxt[ch] = r_rep_cnt[ch];
                  end
               end
               default: begin
                  w_state_nxt[ch] = ST_IDLE;
                  w_hold_nxt[ch]  = '0;
                  w_rep_nxt[ch]   = '0;
               end
            endcase
         end
      end
   end

   // Hold FSM state, counters and pulse outputs.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_state[ch]    <= ST_IDLE;
            r_hold_cnt[ch] <= '0;
            r_rep_cnt[ch]  <= '0;
         end
         r_long   <= '0;
         r_repeat <= '0;
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_state[ch]    <= w_state_nxt[ch];
            r_hold_cnt[ch] <= w_hold_nxt[ch];
            r_rep_cnt[ch]  <= w_rep_nxt[ch];
         end
         r_long   <= w_long_nxt;
         r_repeat <= w_rpt_nxt;
      end
   end

   assign o_pressed    = r_pressed;
   assign o_press      = r_press;
   assign o_release    = r_release;
   assign o_long_press = r_long;
   assign o_repeat     = r_repeat;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with small parameters; edge numbers below
// count rising clock edges from the first edge after reset release (edge 1).
module tb_debounce_bank;

   logic       clk;
   logic       resetn;
   logic [1:0] pins;
   logic [1:0] pressed, press, rel, long_press, rpt;
   int         edge_no;
   int         n_checks;
   int         n_fail;

   debounce_bank #(
      .CHANNELS       (2),
      .SYNC_STAGES    (2),
      .ACTIVE_LOW     (1),
      .DEBOUNCE_CYCLES(4),
      .PRESCALE       (3),
      .HOLD_TICKS     (2),
      .REPEAT_TICKS   (2)
   ) dut (
      .i_clk       (clk),
      .i_resetn    (resetn),
      .i_pins      (pins),
      .o_pressed   (pressed),
      .o_press     (press),
      .o_release   (rel),
      .o_long_press(long_press),
      .o_repeat    (rpt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_no <= edge_no + 1;

   // Park on the falling edge that follows rising edge e.
   task automatic wait_edge(input int e);
      while (edge_no < e) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_press"}, press, 2'b00);
      chk({tag, "_release"}, rel, 2'b00);
      chk({tag, "_long"}, long_press, 2'b00);
      chk({tag, "_repeat"}, rpt, 2'b00);
   endtask

   initial begin
      edge_no  = 0;
      n_checks = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      pins     = 2'b11;
      #1;
      chk("reset_pressed", pressed, 2'b00);
      chk_quiet("reset");
      #1;
      resetn = 1'b1;

      // Clean press on channel 0, then long press and repeats (ticks on edges 3k).
      wait_edge(9);
      pins[0] = 1'b0;
      wait_edge(14);
      chk("t1_pressed_before", pressed, 2'b00);
      chk("t1_press_before", press, 2'b00);
      wait_edge(15);
      chk("t1_pressed", pressed, 2'b01);
      chk("t1_press", press, 2'b01);
      chk("t1_release", rel, 2'b00);
      chk("t1_long", long_press, 2'b00);
      chk("t1_repeat", rpt, 2'b00);
      wait_edge(16);
      chk("t1_press_width", press, 2'b00);
      chk("t1_pressed_hold", pressed, 2'b01);
      wait_edge(20);
      chk("t3_long_early", long_press, 2'b00);
      wait_edge(21);
      chk("t3_long", long_press, 2'b01);
      wait_edge(22);
      chk("t3_long_width", long_press, 2'b00);
      wait_edge(26);
      chk("t3_repeat_early", rpt, 2'b00);
      wait_edge(27);
      chk("t3_repeat1", rpt, 2'b01);
      wait_edge(28);
      chk("t3_repeat_width", rpt, 2'b00);
      wait_edge(33);
      chk("t3_repeat2", rpt, 2'b01);
      wait_edge(35);
      pins[0] = 1'b1;
      wait_edge(39);
      chk("t3_repeat3", rpt, 2'b01);
      wait_edge(40);
      chk("t3_pressed_before_rel", pressed, 2'b01);
      wait_edge(41);
      chk("t3_pressed_rel", pressed, 2'b00);
      chk("t3_release", rel, 2'b01);
      chk("t3_press_at_rel", press, 2'b00);
      wait_edge(42);
      chk("t3_release_width", rel, 2'b00);
      wait_edge(45);
      chk("t3_no_repeat_after_rel", rpt, 2'b00);

      // Release decided on the tick edge where a repeat would be due.
      wait_edge(49);
      pins[0] = 1'b0;
      wait_edge(55);
      chk("t4_press", press, 2'b01);
      wait_edge(60);
      chk("t4_long", long_press, 2'b01);
      pins[0] = 1'b1;
      wait_edge(66);
      chk("t4_release", rel, 2'b01);
      chk("t4_repeat_suppressed", rpt, 2'b00);
      chk("t4_pressed", pressed, 2'b00);
      wait_edge(67);
      chk("t4_repeat_after", rpt, 2'b00);
      wait_edge(69);
      pins[0] = 1'b0;
      wait_edge(75);
      chk("t4_repress", press, 2'b01);
      wait_edge(80);
      chk("t4_long_early", long_press, 2'b00);
      wait_edge(81);
      chk("t4_long_restart", long_press, 2'b01);

      // Asynchronous reset while held in the repeating state.
      wait_edge(85);
      chk("t5_pressed_pre", pressed, 2'b01);
      resetn = 1'b0;
      #1;
      chk("t5_pressed_async", pressed, 2'b00);
      chk_quiet("t5_async");
      wait_edge(87);
      chk("t5_pressed_inreset", pressed, 2'b00);
      chk("t5_repeat_inreset", rpt, 2'b00);
      resetn = 1'b1;
      wait_edge(92);
      chk("t5_pressed_before", pressed, 2'b00);
      wait_edge(93);
      chk("t5_press", press, 2'b01);
      chk("t5_pressed", pressed, 2'b01);
      wait_edge(98);
      chk("t5_long_early", long_press, 2'b00);
      wait_edge(99);
      chk("t5_long", long_press, 2'b01);

      // Independence: release ch0, then press ch0 and ch1 two cycles apart.
      wait_edge(100);
      pins[0] = 1'b1;
      wait_edge(105);
      chk("t6_repeat_before_rel", rpt, 2'b01);
      wait_edge(106);
      chk("t6_release0", rel, 2'b01);
      wait_edge(109);
      pins[0] = 1'b0;
      wait_edge(111);
      pins[1] = 1'b0;
      wait_edge(115);
      chk("t6_press0", press, 2'b01);
      chk("t6_pressed0", pressed, 2'b01);
      wait_edge(116);
      chk("t6_press_gap", press, 2'b00);
      wait_edge(117);
      chk("t6_press1", press, 2'b10);
      chk("t6_pressed_both", pressed, 2'b11);
      wait_edge(120);
      chk("t6_long0", long_press, 2'b01);
      wait_edge(123);
      chk("t6_long1", long_press, 2'b10);
      wait_edge(124);
      pins = 2'b11;
      wait_edge(130);
      chk("t6_release_both", rel, 2'b11);
      chk("t6_pressed_none", pressed, 2'b00);

      // Bounce on ch0: three low samples, one high, then steady low.
      wait_edge(139);
      pins[0] = 1'b0;
      wait_edge(142);
      pins[0] = 1'b1;
      wait_edge(143);
      pins[0] = 1'b0;
      for (int e = 144; e <= 148; e++) begin
         wait_edge(e);
         chk("t2_no_press_glitch", press, 2'b00);
         chk("t2_no_pressed_glitch", pressed, 2'b00);
      end
      wait_edge(149);
      chk("t2_press", press, 2'b01);
      chk("t2_pressed", pressed, 2'b01);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
